test_check_pattern: RTL
=======================

TEST_CHECK_PATTERN -- requirements
Module: test_check_pattern

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 64, number of incrementing data bytes per frame.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload byte width.
REQ-003 SHALL have parameter ETH_TYPE, default 16'h88B5, accepted EtherType.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 clr_counters  in  1  synchronous counter clear.
REQ-007 s_eth_hdr_valid / s_eth_hdr_ready  in / out  1 each  header handshake.
REQ-008 s_eth_dest_mac, s_eth_src_mac  in  48 each  ignored except pkt_src_mac capture.
REQ-009 s_eth_type  in  16  frame EtherType.
REQ-010 s_eth_payload_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  payload stream.
REQ-011 pkt_valid  out  1  one-cycle pulse per completed matching-type frame.
REQ-012 pkt_ok  out  1  frame passed all checks; qualified by pkt_valid.
REQ-013 pkt_timestamp, pkt_index  out  16 each  fields of last matching frame.
REQ-014 pkt_src_mac  out  48  source MAC of last matching frame.
REQ-015 good_count, bad_count, lost_count, drop_count  out  32 each  statistics.

Function
REQ-016 Frame layout SHALL be: flag 8'h07; timestamp 2 bytes LSB first; 3 bytes 8'h00; packet index 2 bytes LSB first; DATA_LENGTH data bytes; tlast on last data byte (total 8+DATA_LENGTH beats).
REQ-017 States SHALL be IDLE, FLAG, TS, ZEROS, INDEX, DATA, WAIT_LAST, DROP.
REQ-018 s_eth_hdr_ready SHALL be 1 only in IDLE; s_eth_payload_axis_tready SHALL be 0 in IDLE, 1 in all other states (no backpressure).
REQ-019 Header fire with s_eth_type==ETH_TYPE -> FLAG, src MAC latched; otherwise -> DROP.
REQ-020 Byte counter SHALL reset to 0 on every state change and increment on each payload fire; TS/INDEX advance after count 1, ZEROS after count 2, DATA after count DATA_LENGTH-1.
REQ-021 Error flag (per frame) SHALL set on: flag !=8'h07, any zero byte !=0, data mismatch, tuser=1 on any beat, tlast before last data byte, missing tlast on last data byte.
REQ-022 Data check: first data byte SHALL seed expected value; each later byte SHALL equal previous+1 mod 2^DATA_WIDTH.
REQ-023 tlast on any beat of FLAG..DATA SHALL end frame immediately (short error) -> IDLE with pkt_valid pulse.
REQ-024 Last data byte without tlast SHALL set error and -> WAIT_LAST; WAIT_LAST and DROP SHALL consume beats until tlast fire, then -> IDLE.
REQ-025 pkt_valid SHALL assert the cycle after the tlast fire of a matching-type frame; pkt_ok = !error; pkt_timestamp/pkt_index update same cycle.
REQ-026 good_count or bad_count SHALL increment with pkt_valid per pkt_ok; drop_count SHALL increment on DROP tlast fire.
REQ-027 Sequence: after first good frame since reset/clr, expected index = last good index+1 mod 2^16; good frame with index != expected SHALL add (index-expected) mod 2^16 to lost_count; first good frame not checked.
REQ-028 All counters SHALL saturate at 32'hFFFFFFFF; clr_counters SHALL zero them and re-arm first-frame sequence skip; clr has priority over simultaneous increment.

Reset
REQ-029 On rst: state IDLE, counters 0, pkt_valid 0, pkt_ok 0, pkt_timestamp/pkt_index/pkt_src_mac 0, sequence unarmed, error flag 0.
REQ-030 rst mid-frame SHALL abandon the frame without pkt_valid or counter update; remaining beats then see tready=0 until next header.

Verification
REQ-031 Two back-to-back valid frames, index 5 then 6, ts 16'h1234, data 0..63 then 64..127 -> two pkt_valid with pkt_ok=1, good_count=2, lost_count=0, pkt_timestamp=16'h1234.
REQ-032 Frames with index 10 then 14 -> lost_count=3, good_count=2.
REQ-033 Frame with data byte 20 corrupted, or flag 8'h06 -> pkt_ok=0, bad_count=1, counter state returns to IDLE after tlast.
REQ-034 Frame with tlast on data byte 30 -> pkt_valid next cycle, pkt_ok=0; frame with 4 extra bytes -> pkt_valid after extra tlast, pkt_ok=0.
REQ-035 Header type 16'h0800, 20-beat payload -> drop_count=1, no pkt_valid; counters at 32'hFFFFFFFF (forced) stay saturated; clr_counters with concurrent increment -> 0.

Source files
------------

// File: rtl/test_check_pattern.sv
// test_check_pattern: checks incrementing-data test frames of one EtherType and keeps
// good/bad/lost/drop statistics plus the fields of the last matching frame.
module test_check_pattern #(
    parameter int          DATA_LENGTH = 64,
    parameter int          DATA_WIDTH  = 8,
    parameter logic [15:0] ETH_TYPE    = 16'h88B5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_counters,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic                  pkt_valid,
    output logic                  pkt_ok,
    output logic [15:0]           pkt_timestamp,
    output logic [15:0]           pkt_index,
    output logic [47:0]           pkt_src_mac,
    output logic [31:0]           good_count,
    output logic [31:0]           bad_count,
    output logic [31:0]           lost_count,
    output logic [31:0]           drop_count
);
    typedef enum logic [2:0] {IDLE, FLAG, TS, ZEROS, INDEX, DATA, WAIT_LAST, DROP} state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, ts_q, idx_q, exp_idx_q, seq_gap;
    logic [DATA_WIDTH-1:0] exp_data_q;
    logic [7:0]            byte_in;
    logic [31:0]           good_q, bad_q, lost_q, drop_q;
    logic [32:0]           lost_sum;
    logic                  err_q, seq_armed_q, pkt_valid_q, pkt_ok_q;
    logic [15:0]           pkt_ts_q, pkt_idx_q;
    logic [47:0]           pkt_src_mac_q;
    logic                  hdr_fire, fire, last_data, beat_err, frame_end, frame_ok, good_end, drop_end;
    logic                  unused_dest;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction

    assign unused_dest               = ^s_eth_dest_mac;
    assign s_eth_hdr_ready           = state_q == IDLE;
    assign s_eth_payload_axis_tready = state_q != IDLE;
    assign hdr_fire                  = s_eth_hdr_valid && s_eth_hdr_ready;
    assign fire                      = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign byte_in                   = 8'(s_eth_payload_axis_tdata);

    always_comb begin
        last_data = state_q == DATA && cnt_q == 16'(DATA_LENGTH - 1);
        beat_err  = s_eth_payload_axis_tuser
            || (state_q == FLAG && s_eth_payload_axis_tdata != DATA_WIDTH'(7))
            || (state_q == ZEROS && s_eth_payload_axis_tdata != '0)
            || (state_q == DATA && cnt_q != '0 && s_eth_payload_axis_tdata != exp_data_q)
            || (state_q inside {FLAG, TS, ZEROS, INDEX} && s_eth_payload_axis_tlast)
            || (state_q == DATA && s_eth_payload_axis_tlast != last_data);
        frame_end = fire && s_eth_payload_axis_tlast && state_q != DROP;
        drop_end  = fire && s_eth_payload_axis_tlast && state_q == DROP;
        frame_ok  = !(err_q || beat_err);
        good_end  = frame_end && frame_ok;
        seq_gap   = idx_q - exp_idx_q;
        lost_sum  = {1'b0, lost_q} + {17'b0, seq_gap};
        state_d   = state_q;
        if (hdr_fire)
            state_d = s_eth_type == ETH_TYPE ? FLAG : DROP;
        else if (fire && s_eth_payload_axis_tlast)
            state_d = IDLE;
        else if (fire && (state_q == FLAG || (state_q inside {TS, INDEX} && cnt_q == 16'd1)
                 || (state_q == ZEROS && cnt_q == 16'd2) || last_data))
            state_d = state_q == FLAG ? TS : state_q == TS ? ZEROS : state_q == ZEROS ? INDEX
                    : state_q == INDEX ? DATA : WAIT_LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            ts_q          <= '0;
            idx_q         <= '0;
            exp_idx_q     <= '0;
            exp_data_q    <= '0;
            seq_armed_q   <= 1'b0;
            pkt_valid_q   <= 1'b0;
            pkt_ok_q      <= 1'b0;
            pkt_ts_q      <= '0;
            pkt_idx_q     <= '0;
            pkt_src_mac_q <= '0;
            good_q        <= '0;
            bad_q         <= '0;
            lost_q        <= '0;
            drop_q        <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= state_d != state_q ? '0 : fire ? cnt_q + 16'd1 : cnt_q;
            err_q   <= hdr_fire ? 1'b0 : fire ? err_q || beat_err : err_q;
            if (hdr_fire && s_eth_type == ETH_TYPE)
                pkt_src_mac_q <= s_eth_src_mac;
            if (fire && state_q == TS)
                ts_q <= cnt_q[0] ? {byte_in, ts_q[7:0]} : {ts_q[15:8], byte_in};
            if (fire && state_q == INDEX)
                idx_q <= cnt_q[0] ? {byte_in, idx_q[7:0]} : {idx_q[15:8], byte_in};
            // Expected data follows the previous byte, so one bad byte does not cascade
            if (fire && state_q == DATA)
                exp_data_q <= s_eth_payload_axis_tdata + DATA_WIDTH'(1);
            pkt_valid_q <= frame_end;
            if (frame_end) begin
                pkt_ok_q  <= frame_ok;
                pkt_ts_q  <= ts_q;
                pkt_idx_q <= idx_q;
            end
            if (clr_counters) begin
                good_q      <= '0;
                bad_q       <= '0;
                lost_q      <= '0;
                drop_q      <= '0;
                seq_armed_q <= 1'b0;
            end else begin
                if (good_end)
                    good_q <= sat_inc(good_q);
                if (frame_end && !frame_ok)
                    bad_q <= sat_inc(bad_q);
                if (drop_end)
                    drop_q <= sat_inc(drop_q);
                if (good_end && seq_armed_q && seq_gap != '0)
                    lost_q <= lost_sum[32] ? '1 : lost_sum[31:0];
                if (good_end) begin
                    seq_armed_q <= 1'b1;
                    exp_idx_q   <= idx_q + 16'd1;
                end
            end
        end
    end

    assign pkt_valid     = pkt_valid_q;
    assign pkt_ok        = pkt_ok_q;
    assign pkt_timestamp = pkt_ts_q;
    assign pkt_index     = pkt_idx_q;
    assign pkt_src_mac   = pkt_src_mac_q;
    assign good_count    = good_q;
    assign bad_count     = bad_q;
    assign lost_count    = lost_q;
    assign drop_count    = drop_q;
endmodule
